// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// single-outstanding req/ack handshake, and holds the fetched word for the
// decoder until downstream releases it.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | just out of reset; the first fetch starts on the next edge
//   FETCH | mem_req high at mem_addr = pc; waiting for mem_ack or timeout
//   EXEC  | instruction/pc valid and held; leaves when stall drops
//   FAULT | memory never answered; frozen until reset
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        inst_valid,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] WORD_MSK = 32'hFFFF_FFFC;
  localparam logic [7:0]  CNT_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [7:0]  cnt_q, cnt_d;

  // State register; reset abandons any request in flight.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: PC, held instruction, flags and ack-timeout counter.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = 8'd0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          instr_d = mem_rdata;
          valid_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          // Counter equals the number of ack-less cycles already spent,
          // so this fires on exactly the ACK_TIMEOUT-th FETCH cycle.
          fault_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        // A branch seen under stall is dropped; the producer re-presents it.
        if (!stall) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
          if (branch_taken) begin
            pc_d = branch_target & WORD_MSK;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      S_FAULT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request and address come straight from registered state, so both stay
  // stable for the whole request.
  always_comb begin
    mem_req  = (state_q == S_FETCH);
    mem_addr = pc_q & WORD_MSK;
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign inst_valid  = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        nRst, nRst2;
  logic [31:0] mem_rdata;
  logic        mem_ack, stall, branch_taken;
  logic [31:0] branch_target;

  logic        mem_req, inst_valid, fetch_fault;
  logic [31:0] mem_addr, instruction, pc;
  logic        mem_req2, inst_valid2, fetch_fault2;
  logic [31:0] mem_addr2, instruction2, pc2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .nRst(nRst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instruction(instruction), .pc(pc), .inst_valid(inst_valid),
    .fetch_fault(fetch_fault)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .ACK_TIMEOUT(3)) dut2 (
    .clk(clk), .nRst(nRst2), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instruction(instruction2), .pc(pc2), .inst_valid(inst_valid2),
    .fetch_fault(fetch_fault2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, " pc"}, pc, 32'h0000_0000);
    check({tag, " instruction"}, instruction, 32'h0000_0013);
    check({tag, " inst_valid"}, {31'd0, inst_valid}, 32'd0);
    check({tag, " fetch_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  // One fetch transaction seen from the memory side. Entered at a negedge
  // with the DUT in FETCH; leaves at the negedge after the DUT re-enters FETCH.
  task automatic run_fetch(input logic [31:0] exp_addr, input int waits,
                           input logic [31:0] rdata, input int stall_cycles,
                           input logic stall_br, input logic br,
                           input logic [31:0] tgt);
    check("fetch mem_req", {31'd0, mem_req}, 32'd1);
    check("fetch mem_addr", mem_addr, exp_addr);
    for (int w = 0; w < waits; w++) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      @(negedge clk);
      check("wait mem_req", {31'd0, mem_req}, 32'd1);
      check("wait mem_addr", mem_addr, exp_addr);
      check("wait inst_valid", {31'd0, inst_valid}, 32'd0);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    check("exec inst_valid", {31'd0, inst_valid}, 32'd1);
    check("exec instruction", instruction, rdata);
    check("exec pc", pc, exp_addr);
    check("exec mem_req", {31'd0, mem_req}, 32'd0);
    for (int s = 0; s < stall_cycles; s++) begin
      stall         = 1'b1;
      branch_taken  = stall_br;
      branch_target = $urandom;
      mem_ack       = 1'($urandom_range(0, 1));
      mem_rdata     = $urandom;
      @(negedge clk);
      check("stall inst_valid", {31'd0, inst_valid}, 32'd1);
      check("stall instruction", instruction, rdata);
      check("stall pc", pc, exp_addr);
      check("stall mem_req", {31'd0, mem_req}, 32'd0);
    end
    stall         = 1'b0;
    branch_taken  = br;
    branch_target = tgt;
    mem_ack       = 1'($urandom_range(0, 1));
    mem_rdata     = $urandom;
    @(negedge clk);
    branch_taken = 1'b0;
    mem_ack      = 1'b0;
    check("refetch inst_valid", {31'd0, inst_valid}, 32'd0);
    check("refetch instruction held", instruction, rdata);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          waits;
    logic [31:0] rdata;
    int          stall_cycles;
    logic        stall_br;
    logic        br;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] exp_addr;
    logic [31:0] last_instr, last_pc;

    // Watchdog: every wait in this bench is a fixed cycle count, this only
    // guards against a broken clock.
    fork
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    vecs[0] = '{32'h0000_0000, 0, 32'h0020_80B3, 0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_0004, 2, 32'h1111_1111, 5, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{32'h0000_0008, 0, 32'h2222_2222, 0, 1'b0, 1'b1, 32'h0000_0103};
    vecs[3] = '{32'h0000_0100, 1, 32'h3333_3333, 2, 1'b1, 1'b0, 32'h0000_0500};
    vecs[4] = '{32'h0000_0104, 3, 32'h4444_4444, 1, 1'b0, 1'b1, 32'hFFFF_FFFE};
    vecs[5] = '{32'hFFFF_FFFC, 0, 32'h5555_5555, 0, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{32'h0000_0000, 1, 32'h6666_6666, 0, 1'b0, 1'b0, 32'h0};

    nRst = 1'b0; nRst2 = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    mem_ack = 1'b0;
    nRst = 1'b1;
    check("idle mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_fetch(vecs[i].addr, vecs[i].waits, vecs[i].rdata, vecs[i].stall_cycles,
                vecs[i].stall_br, vecs[i].br, vecs[i].tgt);
    end
    exp_addr = 32'h0000_0004;

    // Random transactions against a transaction-level PC model
    for (int i = 0; i < 60; i++) begin
      int          w, sc;
      logic        br, sbr;
      logic [31:0] tgt, d;
      w   = $urandom_range(0, 3);
      sc  = $urandom_range(0, 3);
      br  = 1'($urandom_range(0, 2) == 0);
      sbr = 1'($urandom_range(0, 1));
      tgt = $urandom;
      d   = $urandom;
      run_fetch(exp_addr, w, d, sc, sbr, br, tgt);
      exp_addr = br ? (tgt & 32'hFFFF_FFFC) : (exp_addr + 32'd4);
    end

    // Timeout: no ack for 16 FETCH cycles
    last_instr = instruction;
    last_pc    = pc;
    mem_ack    = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check("timeout mem_req", {31'd0, mem_req}, 32'd1);
      check("timeout fault early", {31'd0, fetch_fault}, 32'd0);
      @(negedge clk);
    end
    check("timeout fault", {31'd0, fetch_fault}, 32'd1);
    check("fault mem_req", {31'd0, mem_req}, 32'd0);
    check("fault inst_valid", {31'd0, inst_valid}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
      check("fault sticky", {31'd0, fetch_fault}, 32'd1);
      check("fault frozen instruction", instruction, last_instr);
      check("fault frozen pc", pc, last_pc);
      check("fault frozen valid", {31'd0, inst_valid}, 32'd0);
      check("fault frozen mem_req", {31'd0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;
    nRst = 1'b0;
    #1;
    check_reset_values("fault clear");
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a 3-wait fetch, stale ack during reset
    run_fetch(32'h0, 0, 32'h0000_0013, 0, 1'b0, 1'b1, 32'h0000_0040);
    check("pre-reset addr", mem_addr, 32'h0000_0040);
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b0;
    #1;
    check_reset_values("mid-fetch reset");
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAAD_F00D;
    @(negedge clk);
    check_reset_values("stale ack in reset");
    mem_ack = 1'b0;
    nRst    = 1'b1;
    check("restart idle valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    check("restart valid", {31'd0, inst_valid}, 32'd0);
    run_fetch(32'h0000_0000, 3, 32'h0040_0093, 0, 1'b0, 1'b0, 32'h0);
    check("restart next addr", mem_addr, 32'h0000_0004);

    // Second instance: PC wrap and a short timeout
    nRst = 1'b0;
    @(negedge clk);
    nRst2 = 1'b1;
    @(negedge clk);
    check("wrap first req", {31'd0, mem_req2}, 32'd1);
    check("wrap first addr", mem_addr2, 32'hFFFF_FFFC);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_0013;
    @(negedge clk);
    mem_ack = 1'b0;
    check("wrap instr", instruction2, 32'hCAFE_0013);
    check("wrap pc", pc2, 32'hFFFF_FFFC);
    check("wrap valid", {31'd0, inst_valid2}, 32'd1);
    @(negedge clk);
    check("wrap second addr", mem_addr2, 32'h0000_0000);
    for (int c = 0; c < 3; c++) begin
      check("short timeout mem_req", {31'd0, mem_req2}, 32'd1);
      check("short timeout fault early", {31'd0, fetch_fault2}, 32'd0);
      @(negedge clk);
    end
    check("short timeout fault", {31'd0, fetch_fault2}, 32'd1);
    check("short timeout mem_req off", {31'd0, mem_req2}, 32'd0);
    check("short timeout pc", pc2, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
